iob_csr_uut: RTL and testbench

- IOb-native CSR slave, used as the unit under test for the IOb native simulation server bench.
- Holds two writable 32-bit operand registers, a read-only sum, a read-only version word, a free-running cycle counter and a control register.
- All state advances only when clock-enable is high.

---
 rtl/iob_csr_uut.sv | 108 ++++++++++
 tb/tb_iob_csr_uut.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_csr_uut.sv
// IOb-native CSR slave: two operand registers, their sum, a version word,
// a free-running cycle counter and its control register.
module iob_csr_uut #(
  parameter int          IOB_CSRS_ADDR_W = 5,
  parameter logic [31:0] VERSION         = 32'h0001_0000
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       cke_i,
  input  logic                       iob_valid_i,
  input  logic [IOB_CSRS_ADDR_W-1:0] iob_addr_i,
  input  logic [31:0]                iob_wdata_i,
  input  logic [3:0]                 iob_wstrb_i,
  output logic                       iob_rvalid_o,
  output logic [31:0]                iob_rdata_o,
  output logic                       iob_ready_o
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {
    W_REG_A   = 3'd0,
    W_REG_B   = 3'd1,
    W_SUM     = 3'd2,
    W_VERSION = 3'd3,
    W_CNT     = 3'd4,
    W_CTRL    = 3'd5
  } widx_t;

  logic [31:0] reg_a, reg_b, cnt, sum, rd_word;
  logic        ctrl_en;
  logic        upper_nz, accept, is_wr, wr_en, rd_en;
  logic        sel_a, sel_b, sel_ctrl, cnt_clr;
  logic [2:0]  widx;

  // Any set address bit above the 8-slot window maps to nothing.
  generate
    if (IOB_CSRS_ADDR_W > 5) begin : g_upper
      assign upper_nz = |iob_addr_i[IOB_CSRS_ADDR_W-1:5];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

  assign iob_ready_o = cke_i & arst_i;
  assign accept      = iob_valid_i & iob_ready_o;
  assign is_wr       = |iob_wstrb_i;
  assign wr_en       = accept & is_wr;
  assign rd_en       = accept & ~is_wr;
  assign widx        = iob_addr_i[4:2];

  assign sel_a    = wr_en & ~upper_nz & (widx == W_REG_A);
  assign sel_b    = wr_en & ~upper_nz & (widx == W_REG_B);
  assign sel_ctrl = wr_en & ~upper_nz & (widx == W_CTRL) & iob_wstrb_i[0];
  assign cnt_clr  = sel_ctrl & iob_wdata_i[1];
  assign sum      = reg_a + reg_b;

  logic unused_ok;
  assign unused_ok = ^{iob_addr_i[1:0], iob_wdata_i[31:2]};

  always_comb begin
    rd_word = '0;
    if (!upper_nz) begin
      case (widx)
        W_REG_A:   rd_word = reg_a;
        W_REG_B:   rd_word = reg_b;
        W_SUM:     rd_word = sum;
        W_VERSION: rd_word = VERSION;
        W_CNT:     rd_word = cnt;
        W_CTRL:    rd_word = {31'd0, ctrl_en};
        default:   rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (sel_a && iob_wstrb_i[i]) reg_a[i*8 +: 8] <= iob_wdata_i[i*8 +: 8];
        if (sel_b && iob_wstrb_i[i]) reg_b[i*8 +: 8] <= iob_wdata_i[i*8 +: 8];
      end
    end
  end

  // Clear wins over increment; the increment uses the enable as it was before this edge.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      ctrl_en <= 1'b0;
      cnt     <= '0;
    end else if (cke_i) begin
      if (sel_ctrl) ctrl_en <= iob_wdata_i[0];
      if (cnt_clr)      cnt <= '0;
      else if (ctrl_en) cnt <= cnt + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      iob_rvalid_o <= 1'b0;
      iob_rdata_o  <= '0;
    end else if (cke_i) begin
      iob_rvalid_o <= rd_en;
      if (rd_en) iob_rdata_o <= rd_word;
    end
  end
endmodule

// File: tb/tb_iob_csr_uut.sv
// Scoreboard bench for iob_csr_uut: reads push expectations, a monitor pops
// and compares them whenever a fresh rvalid appears.
module tb_iob_csr_uut;
  localparam logic [4:0] A_REG_A = 5'h00, A_REG_B = 5'h04, A_SUM = 5'h08,
                         A_VER = 5'h0C, A_CNT = 5'h10, A_CTRL = 5'h14,
                         A_UN6 = 5'h18, A_UN7 = 5'h1C;

  logic        clk_i, arst_i, cke_i, iob_valid_i;
  logic [4:0]  iob_addr_i;
  logic [31:0] iob_wdata_i;
  logic [3:0]  iob_wstrb_i;
  logic        iob_rvalid_o, iob_ready_o;
  logic [31:0] iob_rdata_o;

  typedef struct {
    logic [31:0] d;
    bit          dc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = '0;

  iob_csr_uut #(.IOB_CSRS_ADDR_W(5), .VERSION(32'h0001_0000)) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .cke_i       (cke_i),
    .iob_valid_i (iob_valid_i),
    .iob_addr_i  (iob_addr_i),
    .iob_wdata_i (iob_wdata_i),
    .iob_wstrb_i (iob_wstrb_i),
    .iob_rvalid_o(iob_rvalid_o),
    .iob_rdata_o (iob_rdata_o),
    .iob_ready_o (iob_ready_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // A new response only exists after an edge where cke was high.
  initial begin
    logic cke_s;
    exp_t e;
    forever begin
      @(posedge clk_i);
      cke_s = cke_i;
      #1;
      if (cke_s && iob_rvalid_o) begin
        last_rdata = iob_rdata_o;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%h, required no response", iob_rdata_o);
        end else begin
          e = q.pop_front();
          if (!e.dc && iob_rdata_o !== e.d) begin
            errors++;
            $display("FAIL rdata: got %h, required %h", iob_rdata_o, e.d);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input bit dc = 0);
    @(negedge clk_i);
    iob_valid_i = 1'b1; iob_addr_i = a; iob_wstrb_i = 4'h0;
    @(posedge clk_i);
    if (iob_ready_o) q.push_back('{e, dc});
    else begin
      errors++;
      $display("FAIL rd_ready: got ready=%b, required 1", iob_ready_o);
    end
    #1 iob_valid_i = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk_i);
    iob_valid_i = 1'b1; iob_addr_i = a; iob_wdata_i = d; iob_wstrb_i = s;
    @(posedge clk_i);
    #1 iob_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk_i);
      n++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d responses outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++;
    if (iob_ready_o !== 1'b0 || iob_rvalid_o !== 1'b0 || iob_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b rvalid=%b rdata=%h, required 0 0 0",
               iob_ready_o, iob_rvalid_o, iob_rdata_o);
    end
    arst_i = 1'b1;
    rd(A_REG_A, 32'h0);
    rd(A_REG_B, 32'h0);
    rd(A_CNT,   32'h0);
    rd(A_CTRL,  32'h0);
    rd(A_VER,   32'h0001_0000);
    drain();
  endtask

  task automatic test_rw();
    wr(A_REG_A, 32'hDEAD_BEEF, 4'hF);
    rd(A_REG_A, 32'hDEAD_BEEF);
    wr(A_REG_B, 32'h5555_5555, 4'hF);
    @(negedge clk_i);
    checks++;
    if (iob_rdata_o !== 32'hDEAD_BEEF || iob_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL rdata_hold: got rvalid=%b rdata=%h, required 0 deadbeef", iob_rvalid_o, iob_rdata_o);
    end
    wr(A_REG_A, 32'h00AA_0000, 4'h4);
    rd(A_REG_A, 32'hDEAA_BEEF);
    wr(A_REG_B, 32'hFFFF_FF11, 4'h1);
    rd(A_REG_B, 32'h5555_5511);
    drain();
  endtask

  task automatic test_sum();
    wr(A_REG_A, 32'hFFFF_FFFF, 4'hF);
    wr(A_REG_B, 32'h0000_0002, 4'hF);
    rd(A_SUM, 32'h0000_0001);
    wr(A_SUM, 32'h0000_1234, 4'hF);
    rd(A_SUM, 32'h0000_0001);
    wr(A_VER, 32'h0, 4'hF);
    rd(A_VER, 32'h0001_0000);
    wr(A_REG_B, 32'h0000_0010, 4'hF);
    rd(A_SUM, 32'h0000_000F);
    drain();
  endtask

  // Counter starts at 0 with CTRL=0; edge-by-edge counts give exact values.
  task automatic test_counter();
    wr(A_CTRL, 32'h1, 4'hF);
    repeat (10) @(posedge clk_i);
    rd(A_CNT, 32'd10);
    rd(A_CNT, 32'd11);
    wr(A_CTRL, 32'h3, 4'hF);
    rd(A_CNT, 32'd0);
    rd(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h0, 4'hF);
    rd(A_CNT, 32'd3);
    rd(A_CNT, 32'd3);
    drain();
  endtask

  task automatic test_back_to_back();
    wr(A_REG_A, 32'h0102_0304, 4'hF);
    rd(A_REG_A, 32'h0102_0304);
    rd(A_REG_B, 32'h0000_0010);
    rd(A_SUM,   32'h0102_0314);
    // valid held for three accepting edges: three transactions
    @(negedge clk_i);
    iob_valid_i = 1'b1; iob_addr_i = A_REG_A; iob_wstrb_i = 4'h0;
    repeat (3) begin
      @(posedge clk_i);
      q.push_back('{32'h0102_0304, 1'b0});
    end
    #1 iob_valid_i = 1'b0;
    drain();
  endtask

  task automatic test_cke();
    logic [31:0] c1;
    wr(A_CTRL, 32'h1, 4'hF);
    rd(A_CNT, 32'h0, 1'b1);
    wr(A_VER, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk_i);
    c1 = last_rdata;
    cke_i = 1'b0;
    iob_valid_i = 1'b1; iob_addr_i = A_CNT; iob_wstrb_i = 4'h0;
    repeat (5) begin
      @(posedge clk_i);
      #1;
      checks++;
      if (iob_ready_o !== 1'b0 || iob_rvalid_o !== 1'b0) begin
        errors++;
        $display("FAIL cke_hold: got ready=%b rvalid=%b, required 0 0", iob_ready_o, iob_rvalid_o);
      end
    end
    @(negedge clk_i);
    cke_i = 1'b1;
    @(posedge clk_i);
    q.push_back('{c1 + 32'd2, 1'b0});
    #1 iob_valid_i = 1'b0;
    drain();
    wr(A_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_reset_mid();
    wr(A_REG_A, 32'h1234_5678, 4'hF);
    @(negedge clk_i);
    iob_valid_i = 1'b1; iob_addr_i = A_REG_A; iob_wstrb_i = 4'h0;
    #2 arst_i = 1'b0;
    @(posedge clk_i);
    #1;
    checks++;
    if (iob_rvalid_o !== 1'b0 || iob_ready_o !== 1'b0 || iob_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got rvalid=%b ready=%b rdata=%h, required 0 0 0",
               iob_rvalid_o, iob_ready_o, iob_rdata_o);
    end
    @(negedge clk_i);
    iob_valid_i = 1'b0;
    arst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (iob_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_rvalid: got %b, required 0", iob_rvalid_o);
    end
    rd(A_REG_A, 32'h0);
    rd(A_UN6, 32'h0);
    wr(A_UN7, 32'hFFFF_FFFF, 4'hF);
    rd(A_UN7, 32'h0);
    rd(A_CTRL, 32'h0);
    drain();
  endtask

  initial begin
    arst_i = 1'b0; cke_i = 1'b1; iob_valid_i = 1'b0;
    iob_addr_i = '0; iob_wdata_i = '0; iob_wstrb_i = '0;
    test_reset();
    test_rw();
    test_sum();
    test_counter();
    test_back_to_back();
    test_cke();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
